sram_rw_arbiter: RTL and testbench
==================================

Name: sram_rw_arbiter

Overview:
- Shares the single RW port (port 0) of one 32x256 1RW1R SRAM macro between two requesters, A and B.
- Arbitration is round-robin, one access per cycle, with a fixed read latency.
- After reset, an init sequencer optionally zero-fills the whole array before accepting traffic.
- Sits between the core/loader buses and the macro. Port 1 (read-only) is wired elsewhere and is not touched by this block.

Parameters:
- ADDR_WIDTH, 8, word address width; depth = 1<<ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8).
- INIT_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = ready immediately.

Ports:
- clk  in  1  block clock; the macro's clk0 is driven from the same net.
- rst_n  in  1  asynchronous active-low reset.
- a_valid / b_valid  in  1  request valid.
- a_ready / b_ready  out  1  request accepted this cycle.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_wmask / b_wmask  in  NUM_WMASKS  byte enables; used only when we=1.
- a_addr / b_addr  in  ADDR_WIDTH  word address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse.
- a_rdata / b_rdata  out  DATA_WIDTH  read data; meaningful only while rvalid=1.
- init_done  out  1  high once the block accepts requests.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro write mask.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (async, rst_n=0):
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - a_ready=b_ready=0, a_rvalid=b_rvalid=0, rdata=0, init_done=0.
  - Round-robin pointer reset to A.
  - Pipeline tags cleared. Reset mid-operation drops all in-flight reads; no rvalid is emitted for them.
- FSM states: INIT, RUN.
  - Reset enters INIT if INIT_ON_RESET=1, else RUN.
  - INIT: a 9-bit counter issues one write per cycle with addr=count, din=0, wmask=all ones, web0=0, csb0=0, for addresses 0..255. After the write to 255 is issued, the FSM moves to RUN.
  - init_done is registered: it rises in the first RUN cycle and stays high until reset.
  - Ready is held 0 in INIT.
- Handshake (RUN): a request transfers when valid && ready.
  - ready is combinational from both valids and the pointer.
  - At most one of a_ready/b_ready is high in any cycle.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the side the pointer selects; after any grant, the pointer moves to the other side.
  - The arbiter never grants a requester that is not valid.
- Macro drive: on each grant, the request fields are registered into sram_* on the same clock edge (csb0=0, web0=~we).
  - The macro samples those fields on the following edge.
  - Cycles with no grant drive csb0=1 and web0=1; the other sram_* outputs hold their values.
- Read latency: request accepted in cycle N, macro outputs driven in N+1, macro captures at the end of N+1, dout0 valid after the negedge in N+2.
  - <x>_rvalid pulses in cycle N+2, with <x>_rdata = sram_dout0 (combinational pass-through, gated to 0 when rvalid=0).
  - A two-stage tag pipeline carries {valid, is_read, owner}.
- Writes produce no response.
- Throughput is one accepted request per cycle, back-to-back, including a read immediately after a write to the same address. The macro's negedge write lands before the next capture, so the read returns the new data.
- Responses are returned in request order. There is no response backpressure; requesters must accept rvalid.
- wmask=0 on a write is passed through as a legal no-op.
- Address widths match the macro, so there is no out-of-range case.

Optional Feature:
- SRAM_ARB_STATS_EN defined:
  - Adds outputs stat_a_grants, stat_b_grants and stat_conflicts, each 32 bits and wrapping.
  - stat_conflicts increments on each cycle in RUN where both valids are high.
  - All three clear on reset.
- SRAM_ARB_STATS_EN undefined: these ports and their logic are absent.

Decomposition:
- Shared package sram_arb_pkg holds:
  - Constant SRAM_ADDR_W=8, SRAM_DATA_W=32, SRAM_NUM_WMASKS=4.
  - Typedef arb_state_t {INIT, RUN}.
  - Typedef owner_t {OWN_A, OWN_B}.
  - Struct rsp_tag_t {valid, is_read, owner}.
- One sub-module, sram_rr_arb2: the two-requester round-robin grant logic plus the pointer register.

Test Plan:
- Reset with INIT_ON_RESET=1:
  - Expect 256 write cycles covering addresses 0..255 with din=0 and wmask=4'hF.
  - init_done rises on cycle 257; ready=0 throughout INIT.
  - A read of 0x7F then returns 0x00000000.
- Single-requester access:
  - A writes 0xDEADBEEF to 0x10 with wmask=4'b0101, then reads 0x10 on the next cycle.
  - a_rvalid pulses two cycles after the read is accepted, with a_rdata=0x00AD00EF.
- Contention:
  - A and B both hold valid, reading 0x01 and 0x02, for 4 cycles.
  - Grants alternate A, B, A, B.
  - rvalid alternates owners in the same order, two cycles later.
  - Under SRAM_ARB_STATS_EN: stat_conflicts=4 and each grant counter=2.
- Back-to-back write then read:
  - B writes 0x12345678 to 0xFF, then reads 0xFF in the next cycle.
  - b_rdata=0x12345678, with no idle cycle between the two accesses.
- Reset mid-operation:
  - Assert rst_n=0 in the cycle after a read is accepted.
  - No rvalid appears, sram_csb0=1 immediately, and the INIT sweep restarts from address 0.
- Idle and non-valid cycles:
  - With no valids, csb0 stays at 1 and no rvalid is produced.
  - With INIT_ON_RESET=0, init_done=1 in the first cycle after reset release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared constants and types for the SRAM RW-port arbiter slice.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_NUM_WMASKS : geometry of the 32x256 macro
//   arb_state_t : INIT (zero-fill sweep) / RUN (accepting requests)
//   owner_t     : which requester a response belongs to
//   rsp_tag_t   : per-stage read-response tag {valid, is_read, owner}
package sram_arb_pkg;

    localparam int SRAM_ADDR_W     = 8;
    localparam int SRAM_DATA_W     = 32;
    localparam int SRAM_NUM_WMASKS = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        logic   is_read;
        owner_t owner;
    } rsp_tag_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2
// Two-requester round-robin grant logic with its pointer register.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : grants allowed this cycle (block is accepting)
//   a_valid, b_valid  : request valids
//   gnt_a, gnt_b      : combinational one-hot-or-zero grants
//   ptr               : current priority side (OWN_A after reset)
// Handshake: a request transfers in a cycle where valid && grant are both
// high; grants depend only on the valids, en and the pointer, never on
// anything downstream, and a grant is never given to a non-valid side.
module sram_rr_arb2
    import sram_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   a_valid,
    input  logic   b_valid,
    output logic   gnt_a,
    output logic   gnt_b,
    output owner_t ptr
);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (a_valid && b_valid) begin
                if (ptr == OWN_A) gnt_a = 1'b1;
                else              gnt_b = 1'b1;
            end else if (a_valid) begin
                gnt_a = 1'b1;
            end else if (b_valid) begin
                gnt_b = 1'b1;
            end
        end
    end

    // After any grant the other side gets priority, including uncontended
    // grants, so a lone requester cannot keep priority when contention starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= OWN_A;
        end else if (gnt_a) begin
            ptr <= OWN_B;
        end else if (gnt_b) begin
            ptr <= OWN_A;
        end
    end

endmodule

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter
// Shares port 0 (RW) of a 1RW1R SRAM macro between requesters A and B with
// round-robin arbitration, one access per cycle and a fixed read latency of
// two cycles from acceptance to rvalid. After reset an optional sweep
// zero-fills every word before requests are accepted.
// Ports:
//   clk, rst_n                     : clock (also the macro clk0), async active-low reset
//   <x>_valid/<x>_ready            : request handshake, transfer on valid && ready
//   <x>_we/<x>_wmask/<x>_addr/<x>_wdata : request fields (wmask used for writes only)
//   <x>_rvalid/<x>_rdata           : one-cycle read response, rdata is 0 otherwise
//   init_done                      : high once requests are accepted
//   sram_csb0/web0/wmask0/addr0/din0 : registered macro port-0 drive
//   sram_dout0                     : macro read data (valid after negedge)
//   stat_a_grants/stat_b_grants/stat_conflicts : only with SRAM_ARB_STATS_EN
//   dbg_state                      : current FSM state
// Build option: define SRAM_ARB_STATS_EN to add the 32-bit wrapping counters.
// Handshake: ready is combinational from both valids and the arbiter pointer;
// at most one ready is high per cycle; responses carry no backpressure.
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = SRAM_ADDR_W,
    parameter int DATA_WIDTH    = SRAM_DATA_W,
    parameter int NUM_WMASKS    = SRAM_NUM_WMASKS,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
`ifdef SRAM_ARB_STATS_EN
    output logic [31:0]           stat_a_grants,
    output logic [31:0]           stat_b_grants,
    output logic [31:0]           stat_conflicts,
`endif
    output arb_state_t            dbg_state
);

    // One extra bit so the sweep counter can hold the full depth.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << ADDR_WIDTH) - 1);
    localparam arb_state_t RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

    arb_state_t            state, state_nxt;
    logic [CNT_W-1:0]      init_cnt, init_cnt_nxt;

    logic                  csb_nxt, web_nxt;
    logic [NUM_WMASKS-1:0] wmask_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] din_nxt;

    rsp_tag_t              tag_nxt, tag_s1, tag_s2;

    logic                  arb_en, gnt_a, gnt_b;
    owner_t                rr_ptr;

    // init_done already implies RUN; the state term keeps INIT grant-free
    // even if the two registers were ever to disagree.
    assign arb_en = init_done && (state == RUN);

    sram_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .ptr     (rr_ptr)
    );

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            // Registered with the state so it rises in the first RUN cycle.
            init_done <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        // Idle cycles deselect the macro and keep the other fields stable.
        csb_nxt      = 1'b1;
        web_nxt      = 1'b1;
        wmask_nxt    = sram_wmask0;
        addr_nxt     = sram_addr0;
        din_nxt      = sram_din0;
        tag_nxt      = '0;

        case (state)
            INIT: begin
                csb_nxt      = 1'b0;
                web_nxt      = 1'b0;
                wmask_nxt    = '1;
                addr_nxt     = init_cnt[ADDR_WIDTH-1:0];
                din_nxt      = '0;
                init_cnt_nxt = init_cnt + CNT_W'(1);
                if (init_cnt == LAST_CNT) state_nxt = RUN;
            end
            RUN: begin
                if (gnt_a) begin
                    csb_nxt         = 1'b0;
                    web_nxt         = ~a_we;
                    wmask_nxt       = a_wmask;
                    addr_nxt        = a_addr;
                    din_nxt         = a_wdata;
                    tag_nxt.valid   = 1'b1;
                    tag_nxt.is_read = ~a_we;
                    tag_nxt.owner   = OWN_A;
                end else if (gnt_b) begin
                    csb_nxt         = 1'b0;
                    web_nxt         = ~b_we;
                    wmask_nxt       = b_wmask;
                    addr_nxt        = b_addr;
                    din_nxt         = b_wdata;
                    tag_nxt.valid   = 1'b1;
                    tag_nxt.is_read = ~b_we;
                    tag_nxt.owner   = OWN_B;
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            sram_csb0   <= csb_nxt;
            sram_web0   <= web_nxt;
            sram_wmask0 <= wmask_nxt;
            sram_addr0  <= addr_nxt;
            sram_din0   <= din_nxt;
        end
    end

    // Stage 1 lines up with the macro drive cycle, stage 2 with the cycle in
    // which dout0 holds the captured word. Reset wipes both, so reads in
    // flight at reset never produce a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1 <= tag_nxt;
            tag_s2 <= tag_s1;
        end
    end

    assign a_rvalid = tag_s2.valid && tag_s2.is_read && (tag_s2.owner == OWN_A);
    assign b_rvalid = tag_s2.valid && tag_s2.is_read && (tag_s2.owner == OWN_B);
    assign a_rdata  = a_rvalid ? sram_dout0 : '0;
    assign b_rdata  = b_rvalid ? sram_dout0 : '0;

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_a_grants  <= '0;
            stat_b_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (gnt_a) stat_a_grants <= stat_a_grants + 32'd1;
            if (gnt_b) stat_b_grants <= stat_b_grants + 32'd1;
            if ((state == RUN) && a_valid && b_valid)
                stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_rw_arbiter.sv
module tb_sram_rw_arbiter;
  import sram_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_valid, a_we, b_valid, b_we;
  logic [3:0]  a_wmask, b_wmask;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ready, b_ready, a_rvalid, b_rvalid, init_done;
  logic [31:0] a_rdata, b_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  arb_state_t  dbg_state;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_a_grants, stat_b_grants, stat_conflicts;
  logic [31:0] z_sa, z_sb, z_sc;
`endif

  // second instance: no zero-fill sweep, inputs idle
  logic        z_in = 1'b0;
  logic [3:0]  z_m = 4'h0;
  logic [7:0]  z_a = 8'h0;
  logic [31:0] z_d = 32'h0;
  logic        z_ar, z_br, z_arv, z_brv, z_done, z_csb, z_web;
  logic [31:0] z_ard, z_brd, z_din;
  logic [3:0]  z_wm;
  logic [7:0]  z_addr;
  arb_state_t  z_state;

  sram_rw_arbiter #(.INIT_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0),
`ifdef SRAM_ARB_STATS_EN
    .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
    .stat_conflicts(stat_conflicts),
`endif
    .dbg_state(dbg_state)
  );

  sram_rw_arbiter #(.INIT_ON_RESET(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(z_in), .a_ready(z_ar), .a_we(z_in), .a_wmask(z_m),
    .a_addr(z_a), .a_wdata(z_d), .a_rvalid(z_arv), .a_rdata(z_ard),
    .b_valid(z_in), .b_ready(z_br), .b_we(z_in), .b_wmask(z_m),
    .b_addr(z_a), .b_wdata(z_d), .b_rvalid(z_brv), .b_rdata(z_brd),
    .init_done(z_done), .sram_csb0(z_csb), .sram_web0(z_web),
    .sram_wmask0(z_wm), .sram_addr0(z_addr), .sram_din0(z_din),
    .sram_dout0(z_d),
`ifdef SRAM_ARB_STATS_EN
    .stat_a_grants(z_sa), .stat_b_grants(z_sb), .stat_conflicts(z_sc),
`endif
    .dbg_state(z_state)
  );

  // ---------------- SRAM macro model (captures on posedge, acts on negedge) ----------------
  logic [31:0] mac_mem [256];
  logic        mac_pend = 1'b0;
  logic        mac_we;
  logic [3:0]  mac_mask;
  logic [7:0]  mac_addr;
  logic [31:0] mac_din;
  logic [31:0] mac_dout = 32'h0;
  assign sram_dout0 = mac_dout;

  always @(posedge clk) begin
    mac_pend <= !sram_csb0;
    mac_we   <= !sram_web0;
    mac_mask <= sram_wmask0;
    mac_addr <= sram_addr0;
    mac_din  <= sram_din0;
  end

  always @(negedge clk) begin
    if (mac_pend) begin
      if (mac_we) begin
        for (int l = 0; l < 4; l++)
          if (mac_mask[l]) mac_mem[mac_addr][8*l +: 8] <= mac_din[8*l +: 8];
      end else begin
        mac_dout <= mac_mem[mac_addr];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic [31:0] ref_mem [256];
  logic        ref_ptr;                // 0: A has priority, 1: B has priority
  logic [48:0] exp_q [$];              // {due cycle[15:0], owner, data}

  logic        exp_ar, exp_br, exp_arv, exp_brv;
  logic [31:0] exp_ard, exp_brd;
  logic        obs_ar, obs_br, obs_arv, obs_brv, obs_csb;
  logic [31:0] obs_ard, obs_brd;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    exp_q.delete();
    ref_ptr = 1'b0;
    cyc = 0;
  endtask

  task automatic model_accept(input logic own, input logic we, input logic [3:0] m,
                              input logic [7:0] ad, input logic [31:0] d);
    if (we) begin
      for (int l = 0; l < 4; l++)
        if (m[l]) ref_mem[ad][8*l +: 8] = d[8*l +: 8];
    end else begin
      exp_q.push_back({16'(cyc + 2), own, ref_mem[ad]});
    end
  endtask

  // ---------------- driver: one RUN cycle, entered at posedge+1 ----------------
  task automatic run_cycle(input logic av, input logic aw, input logic [3:0] am,
                           input logic [7:0] aa, input logic [31:0] ad,
                           input logic bv, input logic bw, input logic [3:0] bm,
                           input logic [7:0] ba, input logic [31:0] bd);
    logic ga, gb;
    logic [48:0] h;
    a_valid = av; a_we = aw; a_wmask = am; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_wmask = bm; b_addr = ba; b_wdata = bd;
    ga = 1'b0; gb = 1'b0;
    if (av && bv) begin
      if (!ref_ptr) ga = 1'b1; else gb = 1'b1;
    end else if (av) ga = 1'b1;
    else if (bv) gb = 1'b1;
    exp_ar = ga; exp_br = gb;
    exp_arv = 1'b0; exp_brv = 1'b0; exp_ard = 32'h0; exp_brd = 32'h0;
    if (exp_q.size() > 0 && exp_q[0][48:33] == cyc[15:0]) begin
      h = exp_q.pop_front();
      if (h[32]) begin exp_brv = 1'b1; exp_brd = h[31:0]; end
      else       begin exp_arv = 1'b1; exp_ard = h[31:0]; end
    end
    if (ga) begin model_accept(1'b0, aw, am, aa, ad); ref_ptr = 1'b1; end
    if (gb) begin model_accept(1'b1, bw, bm, ba, bd); ref_ptr = 1'b0; end
    @(negedge clk); #1;
    obs_ar = a_ready; obs_br = b_ready; obs_arv = a_rvalid; obs_brv = b_rvalid;
    obs_ard = a_rdata; obs_brd = b_rdata; obs_csb = sram_csb0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_cycle();
    run_cycle(0, 0, 4'h0, 8'h0, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if ({sram_csb0, sram_web0} !== 2'b11) begin n_fail++; $display("FAIL reset_csb_web: got %b want 11", {sram_csb0, sram_web0}); end
    n_tests++; if ({sram_wmask0, sram_addr0, sram_din0} !== 44'h0) begin n_fail++; $display("FAIL reset_fields: got %h/%h/%h want 0", sram_wmask0, sram_addr0, sram_din0); end
    n_tests++; if ({a_ready, b_ready, a_rvalid, b_rvalid, init_done, z_done} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", {a_ready, b_ready, a_rvalid, b_rvalid, init_done, z_done}); end
    n_tests++; if ({a_rdata, b_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", a_rdata, b_rdata); end
    n_tests++; if (dbg_state !== INIT) begin n_fail++; $display("FAIL reset_state: got %0d want INIT", dbg_state); end
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    n_tests++; if ({a_ready, b_ready, init_done, z_done} !== 4'b0) begin n_fail++; $display("FAIL release_cycle0: got %b want 0000", {a_ready, b_ready, init_done, z_done}); end
    for (int k = 1; k <= 256; k++) begin
      if (k == 250) begin a_valid = 1'b0; b_valid = 1'b0; end
      @(posedge clk); #1;
      n_tests++; if ({sram_csb0, sram_web0, sram_wmask0, sram_din0} !== {2'b00, 4'hF, 32'h0}) begin n_fail++; $display("FAIL init_write k=%0d: got %b%b %h %h want 00 f 0", k, sram_csb0, sram_web0, sram_wmask0, sram_din0); end
      n_tests++; if (sram_addr0 !== 8'(k - 1)) begin n_fail++; $display("FAIL init_addr k=%0d: got %h want %h", k, sram_addr0, 8'(k - 1)); end
      n_tests++; if (init_done !== (k == 256)) begin n_fail++; $display("FAIL init_done k=%0d: got %b want %b", k, init_done, (k == 256)); end
      if (k < 250) begin
        n_tests++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL init_ready k=%0d: got %b want 00", k, {a_ready, b_ready}); end
      end
      if (k == 1) begin
        n_tests++; if (z_done !== 1'b1) begin n_fail++; $display("FAIL noinit_done: got %b want 1", z_done); end
      end
    end
    model_reset();
  endtask

  task automatic test_init_readback();
    run_cycle(1, 0, 4'h0, 8'h7F, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0);
    n_tests++; if (obs_ar !== 1'b1) begin n_fail++; $display("FAIL init_rd_ready: got %b want 1", obs_ar); end
    idle_cycle();
    idle_cycle();
    n_tests++; if ({obs_arv, obs_ard} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL init_rd_data: got %b %h want 1 00000000", obs_arv, obs_ard); end
  endtask

  task automatic test_single();
    run_cycle(1, 1, 4'b0101, 8'h10, 32'hDEADBEEF, 0, 0, 4'h0, 8'h0, 32'h0);
    n_tests++; if (obs_ar !== 1'b1) begin n_fail++; $display("FAIL single_wr_ready: got %b want 1", obs_ar); end
    run_cycle(1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0);
    n_tests++; if (obs_ar !== 1'b1) begin n_fail++; $display("FAIL single_rd_ready: got %b want 1", obs_ar); end
    idle_cycle();
    n_tests++; if (obs_arv !== 1'b0) begin n_fail++; $display("FAIL single_early_rvalid: got %b want 0", obs_arv); end
    idle_cycle();
    n_tests++; if ({obs_arv, obs_ard} !== {1'b1, 32'h00AD00EF}) begin n_fail++; $display("FAIL single_rdata: got %b %h want 1 00ad00ef", obs_arv, obs_ard); end
  endtask

  task automatic test_contention();
`ifdef SRAM_ARB_STATS_EN
    logic [31:0] s_a, s_b, s_c;
`endif
    // a lone B grant hands priority to A
    run_cycle(0, 0, 4'h0, 8'h0, 32'h0, 1, 0, 4'h0, 8'h03, 32'h0);
`ifdef SRAM_ARB_STATS_EN
    s_a = stat_a_grants; s_b = stat_b_grants; s_c = stat_conflicts;
`endif
    for (int i = 0; i < 6; i++) begin
      if (i < 4) run_cycle(1, 0, 4'h0, 8'h01, 32'h0, 1, 0, 4'h0, 8'h02, 32'h0);
      else       idle_cycle();
      if (i < 4) begin
        n_tests++; if ({obs_ar, obs_br} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contend_grant i=%0d: got %b want %b", i, {obs_ar, obs_br}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      end
      n_tests++; if ({obs_arv, obs_brv, obs_ard, obs_brd} !== {exp_arv, exp_brv, exp_ard, exp_brd}) begin n_fail++; $display("FAIL contend_rsp i=%0d: got %b%b %h %h want %b%b %h %h", i, obs_arv, obs_brv, obs_ard, obs_brd, exp_arv, exp_brv, exp_ard, exp_brd); end
      if (i == 3) begin
`ifdef SRAM_ARB_STATS_EN
        n_tests++; if ({stat_conflicts - s_c, stat_a_grants - s_a, stat_b_grants - s_b} !== {32'd4, 32'd2, 32'd2}) begin n_fail++; $display("FAIL contend_stats: got %0d %0d %0d want 4 2 2", stat_conflicts - s_c, stat_a_grants - s_a, stat_b_grants - s_b); end
`endif
      end
    end
    // order check: the 4 contended reads answer A,B,A,B at cycles +2..+5
  endtask

  task automatic test_back_to_back();
    run_cycle(0, 0, 4'h0, 8'h0, 32'h0, 1, 1, 4'hF, 8'hFF, 32'h12345678);
    n_tests++; if (obs_br !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready: got %b want 1", obs_br); end
    run_cycle(0, 0, 4'h0, 8'h0, 32'h0, 1, 0, 4'h0, 8'hFF, 32'h0);
    n_tests++; if (obs_br !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_ready: got %b want 1", obs_br); end
    idle_cycle();
    idle_cycle();
    n_tests++; if ({obs_brv, obs_brd} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL b2b_rdata: got %b %h want 1 12345678", obs_brv, obs_brd); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      if (i > 0) begin
        n_tests++; if ({obs_csb, obs_arv, obs_brv} !== 3'b100) begin n_fail++; $display("FAIL idle i=%0d: got csb/rv %b want 100", i, {obs_csb, obs_arv, obs_brv}); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                8'($urandom_range(16, 31)), $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                8'($urandom_range(16, 31)), $urandom());
      n_tests++; if ({obs_ar, obs_br} !== {exp_ar, exp_br}) begin n_fail++; $display("FAIL rand_grant i=%0d: got %b want %b", i, {obs_ar, obs_br}, {exp_ar, exp_br}); end
      n_tests++; if ({obs_arv, obs_brv, obs_ard, obs_brd} !== {exp_arv, exp_brv, exp_ard, exp_brd}) begin n_fail++; $display("FAIL rand_rsp i=%0d: got %b%b %h %h want %b%b %h %h", i, obs_arv, obs_brv, obs_ard, obs_brd, exp_arv, exp_brv, exp_ard, exp_brd); end
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      n_tests++; if ({obs_arv, obs_brv, obs_ard, obs_brd} !== {exp_arv, exp_brv, exp_ard, exp_brd}) begin n_fail++; $display("FAIL rand_drain i=%0d: got %b%b %h %h want %b%b %h %h", i, obs_arv, obs_brv, obs_ard, obs_brd, exp_arv, exp_brv, exp_ard, exp_brd); end
    end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int t;
    run_cycle(1, 0, 4'h0, 8'h20, 32'h0, 0, 0, 4'h0, 8'h0, 32'h0);
    a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++; if (sram_csb0 !== 1'b1) begin n_fail++; $display("FAIL midrst_csb: got %b want 1", sram_csb0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_tests++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL midrst_rvalid i=%0d: got %b want 00", i, {a_rvalid, b_rvalid}); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({sram_csb0, sram_web0, sram_addr0} !== {2'b00, 8'h00}) begin n_fail++; $display("FAIL midrst_sweep0: got %b%b %h want 00 00", sram_csb0, sram_web0, sram_addr0); end
    @(negedge clk); #1;
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_late_rvalid: got %b want 0", a_rvalid); end
    @(posedge clk); #1;
    n_tests++; if (sram_addr0 !== 8'h01) begin n_fail++; $display("FAIL midrst_sweep1: got %h want 01", sram_addr0); end
    t = 0;
    while (!init_done && t < 400) begin @(posedge clk); #1; t++; end
    n_tests++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL midrst_init_timeout: got %b want 1", init_done); end
    model_reset();
    // 0x10 held nonzero data before the reset; the sweep must have cleared it
    run_cycle(0, 0, 4'h0, 8'h0, 32'h0, 1, 0, 4'h0, 8'h10, 32'h0);
    idle_cycle();
    idle_cycle();
    n_tests++; if ({obs_brv, obs_brd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL midrst_refill: got %b %h want 1 00000000", obs_brv, obs_brd); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mac_mem[i] = $urandom();
    test_reset();
    test_init_readback();
    test_single();
    test_contention();
    test_back_to_back();
    test_idle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
